// File: rtl/maze_pkg.sv
// Shared cell codes, FSM state encodings and default geometry for the maze store.
package maze_pkg;

    localparam int MAZE_WIDTH_DEF = 6;

    localparam logic [1:0] CELL_FREE = 2'd0;
    localparam logic [1:0] CELL_WALL = 2'd1;
    localparam logic [1:0] CELL_PATH = 2'd2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

endpackage

// File: rtl/maze_cell_ram.sv
// 2-bit cell array, one synchronous read port and one write port; a read colliding with a
// write on the same edge returns the old contents. The array itself is never reset.
module maze_cell_ram #(
    parameter int addr_width = 12
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [1:0]            rd_data,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [1:0]            wr_data
);

    logic [1:0] mem [2**addr_width];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/maze_store.sv
// Maze cell store: streaming load, solver read/mark port with 1-cycle read latency, and
// a backpressured raster-order readback of the marked maze.
//
//   state    | meaning
//   ST_LOAD  | accepting wall bitmap beats in raster order
//   ST_SERVE | answering solver reads and path marks
//   ST_DUMP  | streaming every cell code back out in raster order
module maze_store
    import maze_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH_DEF,
    parameter int cnt_width  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic                  load_wall,
    output logic                  load_ready,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  dump_req,
    output logic                  dump_valid,
    output logic [1:0]            dump_cell,
    input  logic                  dump_ready,
    output logic                  ready,
    output logic [cnt_width-1:0]  visit_count,
    output logic                  access_err
);

    localparam int aw = 2 * maze_width;

    state_t          state;
    logic [aw-1:0]   raster;
    logic [aw-1:0]   solver_addr;
    logic [aw-1:0]   mark_addr;
    logic [aw-1:0]   dump_addr;
    logic [aw-1:0]   rd_addr;
    logic [aw-1:0]   wr_addr;
    logic [1:0]      rd_data;
    logic [1:0]      eff_rd;
    logic [1:0]      wr_data;
    logic            rd_en;
    logic            wr_en;
    logic            solver_ok;
    logic            srv_rd;
    logic            load_fire;
    logic            dump_fire;
    logic            dump_issue;
    logic            dump_pend;
    logic            raster_last;
    logic            mark_pend;
    logic            mark_wr;
    logic            fwd_d;
    logic            fwd_q;
    logic            oe_live;
    logic            maze_hold;

    assign solver_addr = {row, col};
    assign solver_ok   = (state == ST_SERVE);
    assign srv_rd      = solver_ok && (maze_oe || maze_we);
    assign load_fire   = (state == ST_LOAD) && load_valid && load_ready;
    assign raster_last = &raster;
    assign dump_fire   = dump_valid && dump_ready;
    // Dump reads wait for any in-flight mark so the RAM output it needs is not clobbered.
    assign dump_issue  = (state == ST_DUMP) && !mark_pend &&
                         ((!dump_valid && !dump_pend) || (dump_fire && !raster_last));
    assign dump_addr   = dump_fire ? raster + aw'(1) : raster;

    // A mark is read-modify-write: read at the we edge, write on the next. A read issued
    // while that write is pending sees stale data, so the pending result is forwarded.
    assign eff_rd  = fwd_q ? CELL_PATH : rd_data;
    assign mark_wr = mark_pend && (eff_rd != CELL_WALL);
    assign fwd_d   = srv_rd && mark_pend && (solver_addr == mark_addr) && (eff_rd != CELL_WALL);

    assign rd_en   = srv_rd || dump_issue;
    assign rd_addr = (state == ST_DUMP) ? dump_addr : solver_addr;
    assign wr_en   = load_fire || mark_wr;
    assign wr_addr = load_fire ? raster : mark_addr;
    assign wr_data = load_fire ? {1'b0, load_wall} : CELL_PATH;

    always_comb begin
        maze_in = 1'b1;
        if (state == ST_SERVE) maze_in = oe_live ? (eff_rd == CELL_WALL) : maze_hold;
    end

    maze_cell_ram #(.addr_width(aw)) u_ram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            raster      <= '0;
            load_ready  <= 1'b0;
            dump_valid  <= 1'b0;
            dump_cell   <= CELL_FREE;
            dump_pend   <= 1'b0;
            ready       <= 1'b0;
            visit_count <= '0;
            access_err  <= 1'b0;
            mark_pend   <= 1'b0;
            mark_addr   <= '0;
            fwd_q       <= 1'b0;
            oe_live     <= 1'b0;
            maze_hold   <= 1'b1;
        end else begin
            oe_live   <= solver_ok && maze_oe;
            maze_hold <= maze_in;
            fwd_q     <= fwd_d;
            mark_pend <= solver_ok && maze_we;
            if (solver_ok && maze_we) mark_addr <= solver_addr;
            if (mark_pend && (eff_rd == CELL_FREE) && !(&visit_count))
                visit_count <= visit_count + cnt_width'(1);
            if ((mark_pend && (eff_rd == CELL_WALL)) || (!solver_ok && (maze_oe || maze_we)))
                access_err <= 1'b1;

            case (state)
                ST_LOAD: begin
                    if (load_fire && raster_last) begin
                        state      <= ST_SERVE;
                        load_ready <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        load_ready <= 1'b1;
                    end
                    if (load_fire) raster <= raster + aw'(1);
                end
                ST_SERVE: begin
                    if (dump_req) begin
                        state      <= ST_DUMP;
                        raster     <= '0;
                        ready      <= 1'b0;
                        dump_pend  <= 1'b0;
                        dump_valid <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (dump_pend) begin
                        dump_cell  <= eff_rd;
                        dump_valid <= 1'b1;
                        dump_pend  <= 1'b0;
                    end else if (dump_issue) begin
                        dump_pend <= 1'b1;
                    end
                    if (dump_fire) begin
                        dump_valid <= 1'b0;
                        raster     <= raster + aw'(1);
                        if (raster_last) begin
                            state <= ST_SERVE;
                            ready <= 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
